ram_wait_ctrl: RTL and testbench

//  Parametrised single-port data/program memory with a synchronous enable/MFC handshake
//  and programmable access latency (wait states). It serves the CPU control unit's

---
 rtl/ram_wait_ctrl.sv | 114 +++++++++++
 tb/tb_ram_wait_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wait_ctrl.sv
// Single-port memory with enable/MFC handshake and programmable wait states.
// An access is latched on the request edge and committed on entry to DONE.
module ram_wait_ctrl #(
    parameter int    DATA_W      = 8,
    parameter int    ADDR_W      = 8,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] MAR,
    input  logic              enable,
    input  logic              rnw,
    input  logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] MBR,
    output logic              MFC,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD =
        4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_rnw;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              commit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_rnw;

    // With no wait states the commit edge is the request edge itself,
    // so the live inputs are used instead of the latched copies.
    always_comb begin
        commit   = 1'b0;
        acc_addr = lat_addr;
        acc_data = lat_data;
        acc_rnw  = lat_rnw;
        if (state == ST_IDLE) begin
            acc_addr = MAR;
            acc_data = bus;
            acc_rnw  = rnw;
            commit   = enable && (WAIT_CYCLES == 0);
        end else if (state == ST_BUSY) begin
            commit   = (cnt == 4'd0);
        end
        if (RST) begin
            commit = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (commit && !acc_rnw) begin
            mem[acc_addr] <= acc_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rnw  <= 1'b0;
            MBR      <= '0;
        end else begin
            if (commit && acc_rnw) begin
                MBR <= mem[acc_addr];
            end
            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        lat_addr <= MAR;
                        lat_data <= bus;
                        lat_rnw  <= rnw;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign MFC  = (state == ST_DONE);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Directed bench for ram_wait_ctrl with 0, 2 and 3 wait states.
// Preloaded words are written through the port before being read.
module tb_ram_wait_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] MAR;
    logic       rnw;
    logic [7:0] bus;
    logic       en0, en2, en3;
    logic [7:0] mbr0, mbr2, mbr3;
    logic       mfc0, mfc2, mfc3;
    logic       busy0, busy2, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    ram_wait_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
        .CLK(CLK), .RST(RST), .MAR(MAR), .enable(en0), .rnw(rnw),
        .bus(bus), .MBR(mbr0), .MFC(mfc0), .busy(busy0)
    );

    ram_wait_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(2)) u_w2 (
        .CLK(CLK), .RST(RST), .MAR(MAR), .enable(en2), .rnw(rnw),
        .bus(bus), .MBR(mbr2), .MFC(mfc2), .busy(busy2)
    );

    ram_wait_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
        .CLK(CLK), .RST(RST), .MAR(MAR), .enable(en3), .rnw(rnw),
        .bus(bus), .MBR(mbr3), .MFC(mfc3), .busy(busy3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_en(input int inst, input logic v);
        case (inst)
            0:       en0 = v;
            2:       en2 = v;
            default: en3 = v;
        endcase
    endtask

    function automatic logic get_mfc(input int inst);
        case (inst)
            0:       return mfc0;
            2:       return mfc2;
            default: return mfc3;
        endcase
    endfunction

    // Raises enable and counts edges until MFC, bounded at 20.
    task automatic run_op(input int inst, input logic r,
                          input logic [7:0] a, input logic [7:0] d,
                          output int edges);
        MAR = a;
        rnw = r;
        bus = d;
        set_en(inst, 1'b1);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (get_mfc(inst)) break;
        end
    endtask

    task automatic release_op(input int inst);
        set_en(inst, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        int e;
        n_checks++;
        if (mfc3 !== 1'b0 || busy3 !== 1'b0 || mbr3 !== 8'h00) begin
            $display("FAIL rst_state mfc=%0b busy=%0b mbr=%h required 0 0 00",
                     mfc3, busy3, mbr3);
            n_fail++;
        end
        MAR = 8'h05;
        rnw = 1'b0;
        bus = 8'hAA;
        en3 = 1'b1;
        tick();
        n_checks++;
        if (busy3 !== 1'b1) begin
            $display("FAIL rst_busy_before actual=%0b required=1", busy3);
            n_fail++;
        end
        tick();
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (mfc3 !== 1'b0 || busy3 !== 1'b0 || mbr3 !== 8'h00) begin
            $display("FAIL rst_async mfc=%0b busy=%0b mbr=%h required 0 0 00",
                     mfc3, busy3, mbr3);
            n_fail++;
        end
        en3 = 1'b0;
        tick();
        tick();
        tick();
        RST = 1'b0;
        tick();
        run_op(3, 1'b1, 8'h05, 8'h00, e);
        n_checks++;
        if (e !== 4 || mbr3 !== 8'h00) begin
            $display("FAIL rst_abort edges=%0d mbr=%h required 4 00", e, mbr3);
            n_fail++;
        end
        release_op(3);
    endtask

    task automatic test_read_w0();
        int e;
        run_op(0, 1'b0, 8'h01, 8'h24, e);
        release_op(0);
        run_op(0, 1'b0, 8'h00, 8'h11, e);
        release_op(0);
        run_op(0, 1'b1, 8'h01, 8'h00, e);
        n_checks++;
        if (e !== 1 || mbr0 !== 8'h24) begin
            $display("FAIL read_w0 edges=%0d mbr=%h required 1 24", e, mbr0);
            n_fail++;
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (mfc0 !== 1'b1 || busy0 !== 1'b1) begin
            $display("FAIL read_w0_hold mfc=%0b busy=%0b required 1 1",
                     mfc0, busy0);
            n_fail++;
        end
        release_op(0);
        n_checks++;
        if (mfc0 !== 1'b0 || busy0 !== 1'b0) begin
            $display("FAIL read_w0_idle mfc=%0b busy=%0b required 0 0",
                     mfc0, busy0);
            n_fail++;
        end
    endtask

    task automatic test_write_read_w3();
        int e;
        run_op(3, 1'b0, 8'hFF, 8'h5C, e);
        n_checks++;
        if (e !== 4 || mbr3 !== 8'h00) begin
            $display("FAIL write_w3 edges=%0d mbr=%h required 4 00", e, mbr3);
            n_fail++;
        end
        release_op(3);
        run_op(3, 1'b1, 8'hFF, 8'h00, e);
        n_checks++;
        if (e !== 4 || mbr3 !== 8'h5C) begin
            $display("FAIL read_w3 edges=%0d mbr=%h required 4 5c", e, mbr3);
            n_fail++;
        end
        release_op(3);
    endtask

    task automatic test_input_change();
        int e;
        run_op(3, 1'b0, 8'h00, 8'h11, e);
        release_op(3);
        run_op(3, 1'b0, 8'h01, 8'h24, e);
        release_op(3);
        MAR = 8'h00;
        rnw = 1'b1;
        en3 = 1'b1;
        tick();
        MAR = 8'h01;
        rnw = 1'b0;
        bus = 8'hEE;
        e = 1;
        for (int i = 0; i < 20; i++) begin
            if (mfc3) break;
            tick();
            e++;
        end
        n_checks++;
        if (e !== 4 || mbr3 !== 8'h11) begin
            $display("FAIL midop_change edges=%0d mbr=%h required 4 11", e, mbr3);
            n_fail++;
        end
        release_op(3);
        run_op(3, 1'b1, 8'h01, 8'h00, e);
        n_checks++;
        if (mbr3 !== 8'h24) begin
            $display("FAIL midop_no_write actual=%h required=24", mbr3);
            n_fail++;
        end
        release_op(3);
    endtask

    task automatic test_early_drop();
        int e;
        run_op(2, 1'b0, 8'h03, 8'h77, e);
        n_checks++;
        if (e !== 3) begin
            $display("FAIL write_w2 edges=%0d required 3", e);
            n_fail++;
        end
        release_op(2);
        MAR = 8'h03;
        rnw = 1'b1;
        en2 = 1'b1;
        tick();
        en2 = 1'b0;
        n_checks++;
        if (busy2 !== 1'b1 || mfc2 !== 1'b0) begin
            $display("FAIL drop_e0 busy=%0b mfc=%0b required 1 0", busy2, mfc2);
            n_fail++;
        end
        tick();
        n_checks++;
        if (mfc2 !== 1'b0) begin
            $display("FAIL drop_e1 mfc actual=%0b required=0", mfc2);
            n_fail++;
        end
        tick();
        n_checks++;
        if (mfc2 !== 1'b1 || mbr2 !== 8'h77) begin
            $display("FAIL drop_e2 mfc=%0b mbr=%h required 1 77", mfc2, mbr2);
            n_fail++;
        end
        tick();
        n_checks++;
        if (mfc2 !== 1'b0 || busy2 !== 1'b0) begin
            $display("FAIL drop_e3 mfc=%0b busy=%0b required 0 0", mfc2, busy2);
            n_fail++;
        end
    endtask

    task automatic test_held_enable();
        int e;
        int hi;
        run_op(0, 1'b0, 8'h10, 8'h33, e);
        MAR = 8'h11;
        bus = 8'h44;
        hi  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mfc0 === 1'b1) hi++;
        end
        n_checks++;
        if (hi !== 10) begin
            $display("FAIL held_mfc cycles=%0d required 10", hi);
            n_fail++;
        end
        release_op(0);
        run_op(0, 1'b1, 8'h10, 8'h00, e);
        n_checks++;
        if (e !== 1 || mbr0 !== 8'h33) begin
            $display("FAIL held_single edges=%0d mbr=%h required 1 33", e, mbr0);
            n_fail++;
        end
        release_op(0);
        run_op(0, 1'b1, 8'h11, 8'h00, e);
        n_checks++;
        if (mbr0 !== 8'h00) begin
            $display("FAIL held_no_retrig actual=%h required=00", mbr0);
            n_fail++;
        end
        release_op(0);
    endtask

    task automatic test_back_to_back();
        int e;
        int per;
        run_op(3, 1'b1, 8'hFF, 8'h00, e);
        en3 = 1'b0;
        tick();
        per = 1;
        MAR = 8'h00;
        en3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            per++;
            if (mfc3) break;
        end
        n_checks++;
        if (per !== 5 || mbr3 !== 8'h11) begin
            $display("FAIL b2b period=%0d mbr=%h required 5 11", per, mbr3);
            n_fail++;
        end
        release_op(3);
    endtask

    initial begin
        RST = 1'b1;
        MAR = '0;
        rnw = 1'b0;
        bus = '0;
        en0 = 1'b0;
        en2 = 1'b0;
        en3 = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        test_reset();
        test_read_w0();
        test_write_read_w3();
        test_input_change();
        test_early_drop();
        test_held_enable();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
